// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if: ALU-result intake, register-file write port and status outputs of the writeback stage
interface alu_writeback_stage_if #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 5,
    parameter int STALL_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_cout;
    logic [2:0]        in_status;
    logic              in_a_msb;
    logic              in_b_msb;
    logic              in_set_flags;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic [3:0]        flags;
    logic [CW-1:0]     count;
    logic [STALL_W-1:0] stall_cnt;
    modport master (
        output in_valid, in_result, in_cout, in_status, in_a_msb, in_b_msb, in_set_flags, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags, flags, count, stall_cnt
    );
    modport slave (
        input  in_valid, in_result, in_cout, in_status, in_a_msb, in_b_msb, in_set_flags, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags, flags, count, stall_cnt
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: FIFO between the ALU and the register-file write port; owns the NZCV flags register
module alu_writeback_stage #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 5,
    parameter int STALL_W = 16
) (
    input logic clk,
    input logic reset,
    alu_writeback_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0]  r_result [DEPTH];
    logic [TAG_W-1:0]   r_tag    [DEPTH];
    logic [3:0]         r_snap   [DEPTH];
    logic [AW-1:0]      r_wr, r_rd;
    logic [CW-1:0]      r_count;
    logic [3:0]         r_flags;
    logic [STALL_W-1:0] r_stall;
    logic               w_in_ready, w_out_valid, w_push, w_pop, w_v;
    logic [3:0]         w_nzcv, w_snap;
    assign w_in_ready  = r_count != CW'(DEPTH);
    assign w_out_valid = r_count != '0;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    // Overflow from raw operand sign bits, matching the ALU's own rule
    assign w_v    = (bus.in_a_msb & bus.in_b_msb & ~bus.in_result[31]) | (~bus.in_a_msb & ~bus.in_b_msb & bus.in_result[31]);
    assign w_nzcv = {bus.in_status[1], bus.in_status[0], bus.in_cout, w_v};
    assign w_snap = bus.in_set_flags ? w_nzcv : r_flags;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_valid ? r_result[r_rd] : '0;
    assign bus.out_tag    = w_out_valid ? r_tag[r_rd] : '0;
    assign bus.out_flags  = w_out_valid ? r_snap[r_rd] : '0;
    assign bus.flags      = r_flags;
    assign bus.count      = r_count;
    assign bus.stall_cnt  = r_stall;
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_result[r_wr] <= bus.in_result;
            r_tag[r_wr]    <= bus.in_tag;
            r_snap[r_wr]   <= w_snap;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_flags <= '0;
            r_stall <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push && bus.in_set_flags) r_flags <= w_nzcv;
            if (bus.in_valid && !w_in_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed sequence with a scoreboard queue modelling FIFO contents and flags
module tb_alu_writeback_stage;
    localparam int DW = 32, D = 2, TW = 5, SW = 16;
    typedef struct packed {
        logic [DW-1:0] r;
        logic [TW-1:0] t;
        logic [3:0]    f;
    } ent_t;
    logic clk = 0;
    logic reset;
    always #5 clk = ~clk;
    alu_writeback_stage_if #(.DATA_W(DW), .DEPTH(D), .TAG_W(TW), .STALL_W(SW)) bus ();
    alu_writeback_stage #(.DATA_W(DW), .DEPTH(D), .TAG_W(TW), .STALL_W(SW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    ent_t q[$];
    logic [3:0] m_flags = '0;
    int m_stall = 0;
    int pops = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] r, input logic c, input logic [2:0] s,
                         input logic a, input logic b, input logic set, input logic [TW-1:0] t);
        bus.in_valid = v; bus.in_result = r; bus.in_cout = c; bus.in_status = s;
        bus.in_a_msb = a; bus.in_b_msb = b; bus.in_set_flags = set; bus.in_tag = t;
    endtask

    // Check all outputs against the model, advance the model over the coming edge, then step one clock
    task automatic cycle();
        bit push, pop;
        ent_t e;
        logic [3:0] nf;
        logic v;
        #1;
        chk("in_ready", bus.in_ready, q.size() != D);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("count", bus.count, q.size());
        chk("flags", bus.flags, m_flags);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        if (q.size() != 0) begin
            chk("out_result", bus.out_result, q[0].r);
            chk("out_tag", bus.out_tag, q[0].t);
            chk("out_flags", bus.out_flags, q[0].f);
        end else begin
            chk("out_result_empty", bus.out_result, 0);
            chk("out_tag_empty", bus.out_tag, 0);
            chk("out_flags_empty", bus.out_flags, 0);
        end
        if (reset) begin
            q.delete();
            m_flags = '0;
            m_stall = 0;
        end else begin
            push = bus.in_valid && q.size() != D;
            pop  = bus.out_ready && q.size() != 0;
            if (bus.in_valid && q.size() == D && m_stall != 65535) m_stall++;
            v  = (bus.in_a_msb && bus.in_b_msb && !bus.in_result[31]) || (!bus.in_a_msb && !bus.in_b_msb && bus.in_result[31]);
            nf = {bus.in_status[1], bus.in_status[0], bus.in_cout, v};
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (push) begin
                e.r = bus.in_result; e.t = bus.in_tag; e.f = bus.in_set_flags ? nf : m_flags;
                q.push_back(e);
                if (bus.in_set_flags) m_flags = nf;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1;
        bus.out_ready = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        // single push with set_flags
        drive(1, 0, 1, 3'b101, 0, 0, 1, 3);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_result", bus.out_result, 0);
        chk("t1_out_tag", bus.out_tag, 3);
        chk("t1_out_flags", bus.out_flags, 4'b0110);
        chk("t1_flags", bus.flags, 4'b0110);
        bus.out_ready = 1;
        cycle();
        // set_flags=0 keeps flags and snapshots them
        bus.out_ready = 0;
        drive(1, 32'h5, 1, 3'b010, 1, 1, 0, 7);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nf_flags", bus.flags, 4'b0110);
        chk("nf_out_flags", bus.out_flags, 4'b0110);
        chk("nf_out_result", bus.out_result, 32'h5);
        bus.out_ready = 1;
        cycle();
        // signed overflow
        drive(1, 32'h8000_0000, 0, 3'b010, 0, 0, 1, 9);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ovf_flags", bus.flags, 4'b1001);
        chk("ovf_out_flags", bus.out_flags, 4'b1001);
        cycle();
        // fill and back-pressure
        bus.out_ready = 0;
        drive(1, 32'h111, 0, 3'b000, 1, 0, 0, 1);
        cycle();
        drive(1, 32'h222, 0, 3'b000, 1, 0, 0, 2);
        cycle();
        #1;
        chk("fill_count", bus.count, 2);
        chk("fill_in_ready", bus.in_ready, 0);
        drive(1, 32'h333, 1, 3'b111, 1, 1, 1, 4);
        repeat (5) cycle();
        #1;
        chk("bp_stall_cnt", bus.stall_cnt, 5);
        chk("bp_out_tag", bus.out_tag, 1);
        chk("bp_flags", bus.flags, 4'b1001);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1;
        cycle();
        #1;
        chk("drain_out_tag", bus.out_tag, 2);
        cycle();
        #1;
        chk("drain_count", bus.count, 0);
        // continuous stream
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'(10 + i));
            cycle();
            chk("stream_count_le1", bus.count <= 1, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("stream_pops", pops, 8);
        // mid-operation reset while full with an incoming entry
        bus.out_ready = 0;
        drive(1, 32'hA, 1, 3'b101, 0, 0, 1, 20);
        cycle();
        drive(1, 32'hB, 1, 3'b101, 0, 0, 1, 21);
        cycle();
        #1;
        chk("pre_rst_count", bus.count, 2);
        chk("pre_rst_flags", bus.flags, 4'b0110);
        drive(1, 32'hC, 0, 3'b010, 0, 0, 1, 31);
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_flags", bus.flags, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        // reset with a push into a non-full FIFO drops the entry
        drive(1, 32'hD, 1, 3'b101, 0, 0, 1, 22);
        cycle();
        drive(1, 32'hE, 1, 3'b101, 0, 0, 1, 23);
        reset = 1;
        cycle();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        #1;
        chk("rst2_count", bus.count, 0);
        chk("rst2_flags", bus.flags, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Downstream stage of the 32-bit ALU. Captures each ALU result with its carry-out, status bits and a destination tag into a small FIFO.
- Maintains the architectural NZCV flags register.
- Presents entries to the register-file write port over a valid/ready handshake.
- Decouples the combinational ALU from register-file back-pressure.

Parameters:
- DATA_W, 32, width of the result path
- DEPTH, 2, FIFO entries; power of 2, at least 2
- TAG_W, 5, destination-register tag width
- STALL_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an ALU result this cycle
- in_ready  out  1  stage can accept; equals !full
- in_result  in  DATA_W  ALU result
- in_cout  in  1  ALU carry-out
- in_status  in  3  ALU status {C,N,Z}: bit2=C, bit1=N, bit0=Z
- in_a_msb  in  1  bit 31 of ALU operand A
- in_b_msb  in  1  bit 31 of ALU operand B
- in_set_flags  in  1  this op updates the architectural flags
- in_tag  in  TAG_W  destination register
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes the head entry
- out_result  out  DATA_W  head-entry result
- out_tag  out  TAG_W  head-entry tag
- out_flags  out  4  NZCV snapshot stored with the head entry
- flags  out  4  architectural NZCV, bit3=N, bit2=Z, bit1=C, bit0=V
- count  out  clog2(DEPTH)+1  occupancy
- stall_cnt  out  STALL_W  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Handshake events:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Both sample on the rising clk edge.
- Reset (synchronous, reset=1 at the edge) forces:
  - count=0, write and read pointers=0
  - flags=4'b0000, stall_cnt=0
  - out_valid=0
  - out_result, out_tag and out_flags all zero
- Reset has priority over any push or pop in the same cycle. An entry arriving mid-reset is dropped, and nothing is retained across reset.
- Flag computation on push (combinational from the inputs):
  - N=in_status[1], Z=in_status[0], C=in_cout.
  - V=(a&b&~r31)|(~a&~b&r31), with a=in_a_msb, b=in_b_msb, r31=in_result[31].
  - V uses raw operand sign bits; subtraction inversion is not applied (matches the ALU's overflow rule).
- Flag update on push:
  - in_set_flags=1: flags <= new NZCV at the push edge; the stored entry snapshot is the new NZCV.
  - in_set_flags=0: flags are unchanged; the stored snapshot is the current flags value.
- Flags update at accept time, independent of when the entry drains.
- Latency: an entry pushed at edge k gives out_valid=1 after edge k if the FIFO was empty. There is no combinational in-to-out path.
- out_* are direct reads of the head entry.
  - While out_valid=1 && out_ready=0, out_result, out_tag and out_flags hold stable.
  - When count=0, out_result, out_tag and out_flags read as zero.
- Full:
  - in_ready=0 whenever count==DEPTH, even if a pop occurs that cycle (no same-cycle refill when full).
- Simultaneous push and pop with 0<count<DEPTH:
  - count is unchanged and both pointers advance.
  - With count==0 only the push occurs, because out_valid=0.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
- out_ready while empty is ignored. in_* contents are ignored when in_valid=0.
- stall_cnt increments by 1 each cycle with in_valid=1 && in_ready=0, and saturates at all-ones.

Test Plan:
- Reset then a single push: in_result=0, cout=1, status=3'b101, set_flags=1, tag=3 → next cycle out_valid=1, out_result=0, out_tag=3, out_flags=4'b0110, flags=4'b0110.
- Overflow: a_msb=0, b_msb=0, in_result=32'h8000_0000, cout=0, status=3'b010, set_flags=1 → flags=4'b1001.
- set_flags=0: push after flags=4'b0110, result 32'h5 → flags unchanged, entry out_flags=4'b0110.
- Fill and back-pressure: out_ready=0, push 2 entries (tags 1, 2) → count=2, in_ready=0. Hold in_valid=1 for 5 more cycles → stall_cnt=5 and out_tag stays 1. Then set out_ready=1 → tags drain in order 1, 2.
- Continuous stream: out_ready=1 with 8 back-to-back pushes → count stays ≤1, 8 pops in order, pointers wrap with no lost or duplicated tag.
- Mid-operation reset: count=2, flags≠0, assert reset for one cycle during a push → count=0, out_valid=0, flags=0, stall_cnt=0, pushed entry absent.
